alu_decode: RTL

Decode stage that turns 32-bit MIPS instruction words into the control bundle consumed by the ALU: `aluCtrl`, `aluSrc`, sign-extended immediate, register indices and write-back/memory/branch flags. It sits between instruction fetch and the execute stage. It registers its output behind a valid/ready handshake with a 2-entry skid buffer, so execute-stage stalls never drop or duplicate an instruction.

---
 rtl/alu_decode.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/alu_decode.sv
// MIPS32 decode stage: instruction word -> ALU control bundle, registered behind a 2-entry skid buffer.
// Latency 1 cycle; throughput 1/cycle. inReady drops only when both OUT and SKID hold bundles (registered, no outReady path).
// Backpressure holds OUT stable; ALU_DECODE_ILLEGAL_EN adds a per-bundle illegal flag.
module alu_decode (
    input  logic        clk,
    input  logic        rstN,
    input  logic        flush,
    input  logic [31:0] instr,
    input  logic        inValid,
    output logic        inReady,
    output logic        outValid,
    input  logic        outReady,
    output logic [3:0]  aluCtrl,
    output logic        aluSrc,
    output logic [31:0] imm,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  dstReg,
    output logic        regWrite,
    output logic        memRead,
    output logic        memWrite,
    output logic        branch,
    output logic        illegal
);

    typedef struct packed {
        logic [3:0]  alu_ctrl;
        logic        alu_src;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
`ifdef ALU_DECODE_ILLEGAL_EN
        logic        illegal;
`endif
    } bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t  state_q, state_d;
    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    bundle_t dec;
    logic    known;
    logic    accept;

    always_comb begin
        dec         = '0;
        known       = 1'b1;
        dec.rs      = instr[25:21];
        dec.rt      = instr[20:16];
        dec.imm     = {{16{instr[15]}}, instr[15:0]};
        dec.dst_reg = (instr[31:26] == OP_RTYPE) ? instr[15:11] : instr[20:16];
        case (instr[31:26])
            OP_RTYPE: begin
                dec.reg_write = 1'b1;
                case (instr[5:0])
                    6'h20:   dec.alu_ctrl = 4'd0;
                    6'h21:   dec.alu_ctrl = 4'd1;
                    6'h22:   dec.alu_ctrl = 4'd2;
                    6'h23:   dec.alu_ctrl = 4'd3;
                    6'h24:   dec.alu_ctrl = 4'd4;
                    6'h25:   dec.alu_ctrl = 4'd5;
                    6'h00:   dec.alu_ctrl = 4'd6;
                    6'h02:   dec.alu_ctrl = 4'd7;
                    6'h2A:   dec.alu_ctrl = 4'd8;
                    default: known = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                dec.alu_ctrl  = (instr[31:26] == OP_ADDI) ? 4'd0 : 4'd1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_LW: begin
                dec.alu_ctrl  = 4'd1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
            end
            OP_SW: begin
                dec.alu_ctrl  = 4'd1;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.alu_ctrl = (instr[31:26] == OP_BEQ) ? 4'd9 : 4'd10;
                dec.branch   = 1'b1;
            end
            default: known = 1'b0;
        endcase
        // Unrecognised words collapse to a NOP bundle; register fields pass through untouched.
        if (!known) begin
            dec.alu_ctrl  = 4'd0;
            dec.alu_src   = 1'b0;
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
        end
`ifdef ALU_DECODE_ILLEGAL_EN
        dec.illegal = !known;
`endif
    end

    assign inReady = (state_q != TWO);
    assign accept  = inValid && inReady && !flush;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    out_d   = dec;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && !outReady) begin
                    skid_d  = dec;
                    state_d = TWO;
                end else if (accept && outReady) begin
                    out_d   = dec;
                end else if (outReady) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (outReady) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign outValid = (state_q != EMPTY);
    assign aluCtrl  = out_q.alu_ctrl;
    assign aluSrc   = out_q.alu_src;
    assign imm      = out_q.imm;
    assign rs       = out_q.rs;
    assign rt       = out_q.rt;
    assign dstReg   = out_q.dst_reg;
    assign regWrite = out_q.reg_write;
    assign memRead  = out_q.mem_read;
    assign memWrite = out_q.mem_write;
    assign branch   = out_q.branch;
`ifdef ALU_DECODE_ILLEGAL_EN
    assign illegal  = out_q.illegal;
`else
    assign illegal  = 1'b0;
`endif

endmodule
